// File: rtl/buf_chain_checker_pkg.sv
// buf_chain_checker_pkg: shared types and constants for the buffer-chain BIST.
package buf_chain_checker_pkg;

    localparam int LFSR_W = 16;
    // x^16+x^14+x^13+x^11+1 with the register shifting toward bit 0:
    // feedback is the XOR of bits 0, 2, 3 and 5.
    localparam logic [LFSR_W-1:0] LFSR_TAPS    = 16'h002D;
    localparam logic [LFSR_W-1:0] DEFAULT_SEED = 16'hACE1;

    // Phase counter covers LEN (up to 65535) and LAT (up to 64).
    localparam int CNT_W = 16;
    // Width of the first-mismatch index.
    localparam int IDX_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FLUSH,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_e;

    function automatic logic lfsr_fb(input logic [LFSR_W-1:0] s);
        return ^(s & LFSR_TAPS);
    endfunction

endpackage

// File: rtl/buf_chain_lfsr.sv
// buf_chain_lfsr: seedable 16-bit Fibonacci LFSR; load wins over advance.
module buf_chain_lfsr
    import buf_chain_checker_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = DEFAULT_SEED
) (
    input  logic ck,
    input  logic rst,
    input  logic load_i,
    input  logic advance_i,
    output logic bit_o
);

    logic [LFSR_W-1:0] lfsr_q, lfsr_d;

    // Next value: reload the seed, shift toward bit 0, or hold.
    always_comb begin
        lfsr_d = lfsr_q;
        if (load_i) begin
            lfsr_d = SEED;
        end else if (advance_i) begin
            lfsr_d = {lfsr_fb(lfsr_q), lfsr_q[LFSR_W-1:1]};
        end
    end

    // LFSR state register.
    always_ff @(posedge ck) begin
        if (rst) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign bit_o = lfsr_q[0];

endmodule

// File: rtl/buf_chain_checker.sv
// buf_chain_checker: launches an LFSR stream into a buffer chain and checks
// the far end against a LAT-deep delayed copy of what was launched.
// Optional feature macro: BUF_CHAIN_CHECKER_FIRST_ERR_EN adds the first_err
// output (RUN bit index of the first mismatch).
module buf_chain_checker
    import buf_chain_checker_pkg::*;
#(
    parameter int                LAT   = 2,
    parameter int                LEN   = 256,
    parameter int                ERR_W = 8,
    parameter logic [LFSR_W-1:0] SEED  = DEFAULT_SEED
) (
    input  logic             ck,
    input  logic             rst,
    input  logic             start,
    input  logic             q_in,
    output logic             i_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_cnt
`ifdef BUF_CHAIN_CHECKER_FIRST_ERR_EN
    ,
    output logic [IDX_W-1:0] first_err
`endif
);

    localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(LAT - 1);
    localparam logic [CNT_W-1:0] RUN_LAST   = CNT_W'(LEN - 1);
    // The launch register adds one cycle between the RUN state and the bit
    // appearing on i_out, so DRAIN spans LAT+1 state cycles to let the last
    // launched bit reach the pipeline tail and be compared.
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(LAT);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             accept, launch, drain_end;
    logic             lfsr_bit;
    logic             i_out_q, i_out_d;
    logic [LAT-1:0]   exp_vld_q, exp_vld_d;
    logic [LAT-1:0]   exp_bit_q, exp_bit_d;
    logic             tail_vld, mism;
    logic [ERR_W-1:0] err_q, err_d;
    logic             pass_q, pass_d;

    assign accept    = (state_q == ST_IDLE) && start;
    assign launch    = (state_q == ST_RUN);
    assign drain_end = (state_q == ST_DRAIN) && (cnt_q == DRAIN_LAST);

    buf_chain_lfsr #(
        .SEED(SEED)
    ) u_lfsr (
        .ck       (ck),
        .rst      (rst),
        .load_i   (accept),
        .advance_i(launch),
        .bit_o    (lfsr_bit)
    );

    // FSM state and phase counter registers.
    always_ff @(posedge ck) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // FSM next state: each phase counts its own length and restarts the counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (start) state_d = ST_FLUSH;
            end
            ST_FLUSH: begin
                if (cnt_q == FLUSH_LAST) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end
            end
            ST_RUN: begin
                if (cnt_q == RUN_LAST) begin
                    state_d = ST_DRAIN;
                    cnt_d   = '0;
                end
            end
            ST_DRAIN: begin
                if (drain_end) begin
                    state_d = ST_DONE;
                    cnt_d   = '0;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // FSM outputs decoded from the registered state.
    always_comb begin
        busy = (state_q == ST_FLUSH) || (state_q == ST_RUN) || (state_q == ST_DRAIN);
        done = (state_q == ST_DONE);
    end

    assign tail_vld = exp_vld_q[LAT-1];
    assign mism     = tail_vld && (q_in != exp_bit_q[LAT-1]);

    // Datapath next state: launch bit, expected pipeline, error count, pass flag.
    always_comb begin
        i_out_d      = launch ? lfsr_bit : 1'b0;
        exp_vld_d    = exp_vld_q;
        exp_bit_d    = exp_bit_q;
        exp_vld_d[0] = launch;
        exp_bit_d[0] = launch & lfsr_bit;
        for (int i = 1; i < LAT; i++) begin
            exp_vld_d[i] = exp_vld_q[i-1];
            exp_bit_d[i] = exp_bit_q[i-1];
        end

        err_d = err_q;
        if (accept) begin
            err_d = '0;
        end else if (mism && (err_q != {ERR_W{1'b1}})) begin
            err_d = err_q + ERR_W'(1);
        end

        pass_d = pass_q;
        if (accept) begin
            pass_d = 1'b0;
        end else if (drain_end) begin
            pass_d = (err_d == '0);
        end
    end

    // Datapath registers.
    always_ff @(posedge ck) begin
        if (rst) begin
            i_out_q   <= 1'b0;
            exp_vld_q <= '0;
            exp_bit_q <= '0;
            err_q     <= '0;
            pass_q    <= 1'b0;
        end else begin
            i_out_q   <= i_out_d;
            exp_vld_q <= exp_vld_d;
            exp_bit_q <= exp_bit_d;
            err_q     <= err_d;
            pass_q    <= pass_d;
        end
    end

    assign i_out   = i_out_q;
    assign err_cnt = err_q;
    assign pass    = pass_q;

`ifdef BUF_CHAIN_CHECKER_FIRST_ERR_EN
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] first_err_q, first_err_d;

    // Count checked bits; latch the index of the first mismatch of the run.
    always_comb begin
        idx_d       = idx_q;
        first_err_d = first_err_q;
        if (accept) begin
            idx_d       = '0;
            first_err_d = '1;
        end else if (tail_vld) begin
            idx_d = idx_q + IDX_W'(1);
            if (mism && (err_q == '0)) first_err_d = idx_q;
        end
    end

    // First-error registers.
    always_ff @(posedge ck) begin
        if (rst) begin
            idx_q       <= '0;
            first_err_q <= '1;
        end else begin
            idx_q       <= idx_d;
            first_err_q <= first_err_d;
        end
    end

    assign first_err = first_err_q;
`endif

endmodule

// File: tb/tb_buf_chain_checker.sv
// tb_buf_chain_checker: randomized self-checking bench. The buffer chain is a
// behavioural delay line with optional inversion, per-bit noise in the
// comparison window and junk outside it; expected results come from the
// launched LFSR sequence and plain bit-by-bit comparison rules.
module tb_buf_chain_checker;

    localparam int LAT     = 2;
    localparam int LEN     = 256;
    localparam int ERR_W   = 8;
    localparam int SAT     = (1 << ERR_W) - 1;
    localparam int RUN_CYC = 2 * LAT + LEN + 1;

    logic             ck = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             q_in;
    logic             i_out, busy, done, pass;
    logic [ERR_W-1:0] err_cnt;
`ifdef BUF_CHAIN_CHECKER_FIRST_ERR_EN
    logic [15:0]      first_err;
`endif

    int          n_chk = 0;
    int          n_pass = 0;
    int          cyc = 0;
    int          e0 = -100000;
    int          dly = LAT;
    bit          inv_en = 1'b0;
    bit          junk_en = 1'b0;
    logic [31:0] junk_w = '0;
    bit          noise[LEN];
    bit          seq[LEN];
    logic [7:0]  hist = '0;

    buf_chain_checker #(
        .LAT  (LAT),
        .LEN  (LEN),
        .ERR_W(ERR_W),
        .SEED (16'hACE1)
    ) dut (
        .ck     (ck),
        .rst    (rst),
        .start  (start),
        .q_in   (q_in),
        .i_out  (i_out),
        .busy   (busy),
        .done   (done),
        .pass   (pass),
        .err_cnt(err_cnt)
`ifdef BUF_CHAIN_CHECKER_FIRST_ERR_EN
        ,
        .first_err(first_err)
`endif
    );

    always #5 ck = ~ck;

    always @(posedge ck) begin
        cyc  <= cyc + 1;
        hist <= {hist[6:0], i_out};
    end

    // Chain model: a bit driven on i_out is visible on q_in dly-1 cycles later.
    always_comb begin
        int   rel;
        logic b;
        rel = cyc - e0;
        if (dly <= 1) b = i_out;
        else          b = hist[dly-2];
        if (rel >= 2 * LAT && rel < 2 * LAT + LEN) b = b ^ inv_en ^ noise[rel - 2 * LAT];
        else if (junk_en) b = junk_w[cyc % 32];
        q_in = b;
    end

    // Reference: mismatches the checker must count for chain delay d.
    function automatic int model_errs(input int d, input bit inv, output int first);
        int n;
        n = 0;
        first = 16'hFFFF;
        for (int k = 0; k < LEN; k++) begin
            int j;
            bit src;
            bit q;
            j   = k + LAT - d;
            src = (j >= 0 && j < LEN) ? seq[j] : 1'b0;
            q   = src ^ inv ^ noise[k];
            if (q != seq[k]) begin
                if (n == 0) first = k;
                n++;
            end
        end
        return (n > SAT) ? SAT : n;
    endfunction

    task automatic gen_seq();
        int l;
        int fb;
        l = 16'hACE1;
        for (int k = 0; k < LEN; k++) begin
            seq[k] = l[0];
            fb = (l ^ (l >> 2) ^ (l >> 3) ^ (l >> 5)) & 1;
            l  = (l >> 1) | (fb << 15);
        end
    endtask

    task automatic clear_noise();
        for (int k = 0; k < LEN; k++) noise[k] = 1'b0;
    endtask

    // Launch one run and follow it to the done cycle (returns inside it).
    task automatic do_run(input int pulse_at, output int done_at, output int iout_bad,
                          output int busy_bad);
        int rel;
        done_at  = -1;
        iout_bad = 0;
        busy_bad = 0;
        start = 1'b1;
        @(posedge ck); #1;
        start = 1'b0;
        e0 = cyc;
        for (int i = 0; i < RUN_CYC + 40; i++) begin
            rel = cyc - e0;
            if (done === 1'b1) begin
                done_at = rel;
                break;
            end
            if (busy !== 1'b1) busy_bad++;
            if (rel >= LAT + 1 && rel < LAT + 1 + LEN) begin
                if (i_out !== seq[rel - LAT - 1]) iout_bad++;
            end else if (i_out !== 1'b0) begin
                iout_bad++;
            end
            start = (rel == pulse_at);
            @(posedge ck); #1;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge ck);
        #1;
        n_chk++; if (i_out !== 1'b0) $display("FAIL reset.i_out got %b want 0", i_out); else n_pass++;
        n_chk++; if (busy !== 1'b0) $display("FAIL reset.busy got %b want 0", busy); else n_pass++;
        n_chk++; if (done !== 1'b0) $display("FAIL reset.done got %b want 0", done); else n_pass++;
        n_chk++; if (pass !== 1'b0) $display("FAIL reset.pass got %b want 0", pass); else n_pass++;
        n_chk++; if (err_cnt !== '0) $display("FAIL reset.err_cnt got %0d want 0", err_cnt); else n_pass++;
`ifdef BUF_CHAIN_CHECKER_FIRST_ERR_EN
        n_chk++; if (first_err !== 16'hFFFF) $display("FAIL reset.first_err got %h want ffff", first_err); else n_pass++;
`endif
        rst = 1'b0;
        repeat (10) @(posedge ck);
        #1;
    endtask

    task automatic test_ideal();
        int da, ib, bb, fe;
        dly = LAT; inv_en = 1'b0; junk_en = 1'b0; clear_noise();
        do_run(-1, da, ib, bb);
        n_chk++; if (da !== RUN_CYC) $display("FAIL ideal.done_at got %0d want %0d", da, RUN_CYC); else n_pass++;
        n_chk++; if (ib !== 0) $display("FAIL ideal.i_out_stream got %0d bad want 0", ib); else n_pass++;
        n_chk++; if (bb !== 0) $display("FAIL ideal.busy got %0d low cycles want 0", bb); else n_pass++;
        n_chk++; if (busy !== 1'b0) $display("FAIL ideal.busy_in_done got %b want 0", busy); else n_pass++;
        n_chk++; if (err_cnt !== ERR_W'(model_errs(LAT, 1'b0, fe))) $display("FAIL ideal.err_cnt got %0d want 0", err_cnt); else n_pass++;
        n_chk++; if (pass !== 1'b1) $display("FAIL ideal.pass got %b want 1", pass); else n_pass++;
        @(posedge ck); #1;
        n_chk++; if (done !== 1'b0) $display("FAIL ideal.done_width got %b want 0", done); else n_pass++;
        repeat (5) @(posedge ck);
        #1;
        n_chk++; if (pass !== 1'b1) $display("FAIL ideal.pass_hold got %b want 1", pass); else n_pass++;
    endtask

    task automatic test_saturation();
        int da, ib, bb, fe, ex;
        dly = LAT; inv_en = 1'b1; junk_en = 1'b0; clear_noise();
        ex = model_errs(LAT, 1'b1, fe);
        do_run(-1, da, ib, bb);
        n_chk++; if (err_cnt !== ERR_W'(ex)) $display("FAIL sat.err_cnt got %0d want %0d", err_cnt, ex); else n_pass++;
        n_chk++; if (pass !== 1'b0) $display("FAIL sat.pass got %b want 0", pass); else n_pass++;
        repeat (4) @(posedge ck);
        #1;
        n_chk++; if (err_cnt !== ERR_W'(SAT)) $display("FAIL sat.hold got %0d want %0d", err_cnt, SAT); else n_pass++;
        inv_en = 1'b0;
    endtask

    task automatic test_random_noise();
        int da, ib, bb, fe, ex;
        for (int it = 0; it < 3; it++) begin
            dly = LAT; inv_en = 1'b0; junk_en = 1'b1; junk_w = $urandom;
            for (int k = 0; k < LEN; k++) noise[k] = ($urandom_range(0, 5 + it * 8) == 0);
            ex = model_errs(LAT, 1'b0, fe);
            do_run(-1, da, ib, bb);
            n_chk++; if (err_cnt !== ERR_W'(ex)) $display("FAIL noise%0d.err_cnt got %0d want %0d", it, err_cnt, ex); else n_pass++;
            n_chk++; if (pass !== (ex == 0)) $display("FAIL noise%0d.pass got %b want %b", it, pass, ex == 0); else n_pass++;
`ifdef BUF_CHAIN_CHECKER_FIRST_ERR_EN
            n_chk++; if (first_err !== 16'(fe)) $display("FAIL noise%0d.first_err got %0d want %0d", it, first_err, fe); else n_pass++;
`endif
            @(posedge ck); #1;
        end
        junk_en = 1'b0; clear_noise();
    endtask

    task automatic test_latency();
        int da, ib, bb, fe, ex;
        int dl[3] = '{3, 1, 2};
        for (int t = 0; t < 3; t++) begin
            dly = dl[t]; inv_en = 1'b0; junk_en = 1'b0; clear_noise();
            ex = model_errs(dl[t], 1'b0, fe);
            do_run(-1, da, ib, bb);
            n_chk++; if (err_cnt !== ERR_W'(ex)) $display("FAIL lat_d%0d.err_cnt got %0d want %0d", dl[t], err_cnt, ex); else n_pass++;
            n_chk++; if ((dl[t] != LAT) && (err_cnt === '0)) $display("FAIL lat_d%0d.nonzero got %0d want >0", dl[t], err_cnt); else n_pass++;
            @(posedge ck); #1;
        end
        dly = LAT;
    endtask

    task automatic test_single_flip();
        int da, ib, bb, fe, ex;
        dly = LAT; inv_en = 1'b0; junk_en = 1'b0; clear_noise();
        noise[5] = 1'b1;
        ex = model_errs(LAT, 1'b0, fe);
        do_run(-1, da, ib, bb);
        n_chk++; if (err_cnt !== ERR_W'(ex)) $display("FAIL flip5.err_cnt got %0d want %0d", err_cnt, ex); else n_pass++;
        n_chk++; if (pass !== 1'b0) $display("FAIL flip5.pass got %b want 0", pass); else n_pass++;
`ifdef BUF_CHAIN_CHECKER_FIRST_ERR_EN
        n_chk++; if (first_err !== 16'd5) $display("FAIL flip5.first_err got %0d want 5", first_err); else n_pass++;
`endif
        clear_noise();
        @(posedge ck); #1;
    endtask

    task automatic test_start_ignored();
        int da, ib, bb, rel;
        dly = LAT; inv_en = 1'b0; junk_en = 1'b0; clear_noise();
        do_run(100, da, ib, bb);
        n_chk++; if (da !== RUN_CYC) $display("FAIL ign.done_at got %0d want %0d", da, RUN_CYC); else n_pass++;
        n_chk++; if (pass !== 1'b1) $display("FAIL ign.pass got %b want 1", pass); else n_pass++;
        // start held from the done cycle: ignored there, accepted one cycle later
        start = 1'b1;
        @(posedge ck); #1;
        n_chk++; if (busy !== 1'b0) $display("FAIL ign.start_in_done got busy=%b want 0", busy); else n_pass++;
        @(posedge ck); #1;
        start = 1'b0;
        e0 = cyc;
        n_chk++; if (busy !== 1'b1) $display("FAIL ign.accept got busy=%b want 1", busy); else n_pass++;
        n_chk++; if (pass !== 1'b0) $display("FAIL ign.pass_clear got %b want 0", pass); else n_pass++;
        rel = -1;
        for (int i = 0; i < RUN_CYC + 40; i++) begin
            if (done === 1'b1) begin
                rel = cyc - e0;
                break;
            end
            @(posedge ck); #1;
        end
        n_chk++; if (rel !== RUN_CYC) $display("FAIL ign.second_done_at got %0d want %0d", rel, RUN_CYC); else n_pass++;
        @(posedge ck); #1;
    endtask

    task automatic test_reset_mid_run();
        int da, ib, bb, fe, ex, dones;
        dly = LAT; inv_en = 1'b0; junk_en = 1'b0;
        for (int k = 0; k < LEN; k++) noise[k] = ($urandom_range(0, 3) == 0);
        noise[0] = 1'b1;
        ex = model_errs(LAT, 1'b0, fe);
        start = 1'b1;
        @(posedge ck); #1;
        start = 1'b0;
        e0 = cyc;
        while (cyc - e0 < 120) begin
            @(posedge ck); #1;
        end
        rst = 1'b1;
        @(posedge ck); #1;
        rst = 1'b0;
        n_chk++; if (busy !== 1'b0) $display("FAIL midrst.busy got %b want 0", busy); else n_pass++;
        n_chk++; if (i_out !== 1'b0) $display("FAIL midrst.i_out got %b want 0", i_out); else n_pass++;
        n_chk++; if (err_cnt !== '0) $display("FAIL midrst.err_cnt got %0d want 0", err_cnt); else n_pass++;
        n_chk++; if (done !== 1'b0) $display("FAIL midrst.done got %b want 0", done); else n_pass++;
`ifdef BUF_CHAIN_CHECKER_FIRST_ERR_EN
        n_chk++; if (first_err !== 16'hFFFF) $display("FAIL midrst.first_err got %h want ffff", first_err); else n_pass++;
`endif
        dones = 0;
        repeat (RUN_CYC) begin
            @(posedge ck); #1;
            if (done === 1'b1 || busy === 1'b1) dones++;
        end
        n_chk++; if (dones !== 0) $display("FAIL midrst.no_done got %0d active cycles want 0", dones); else n_pass++;
        do_run(-1, da, ib, bb);
        n_chk++; if (da !== RUN_CYC) $display("FAIL midrst.rerun_done_at got %0d want %0d", da, RUN_CYC); else n_pass++;
        n_chk++; if (ib !== 0) $display("FAIL midrst.rerun_i_out got %0d bad want 0", ib); else n_pass++;
        n_chk++; if (err_cnt !== ERR_W'(ex)) $display("FAIL midrst.rerun_err got %0d want %0d", err_cnt, ex); else n_pass++;
        clear_noise();
        @(posedge ck); #1;
    endtask

    initial begin
        gen_seq();
        clear_noise();
        test_reset();
        test_ideal();
        test_saturation();
        test_random_noise();
        test_latency();
        test_single_flip();
        test_start_ignored();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
